// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline stall/flush sequencer.
//   - state_e : sequencer states (RUN, MEM_WAIT, MC_BUSY, ERR).
//   - REG_X0  : hardwired-zero register index. It never creates a hazard.
//   - ctrl_t  : bundle of all per-register stall/flush/redirect controls.
//   - CTRL_*  : control patterns for each cause that acts on the pipeline.
package pipe_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int XLEN   = 32;

  localparam logic [REG_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MC_BUSY  = 2'd2,
    ST_ERR      = 2'd3
  } state_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
    logic flush_mem_wb;
    logic pc_redirect;
    logic mc_done;
  } ctrl_t;

  // Memory wait: freeze everything up to EX/MEM and bubble into MEM/WB.
  localparam ctrl_t CTRL_NONE = 10'b0000_0000_00;
  localparam ctrl_t CTRL_MEM  = 10'b1111_0001_00;
  // Multi-cycle EX: freeze the front end and EX, and bubble into EX/MEM.
  localparam ctrl_t CTRL_MC   = 10'b1110_0010_00;
  // Taken branch: redirect the PC and squash the two younger instructions.
  localparam ctrl_t CTRL_BR   = 10'b0000_1100_10;
  // Load-use: hold PC and IF/ID for one cycle and bubble into ID/EX.
  localparam ctrl_t CTRL_LU   = 10'b1100_0100_00;
  localparam ctrl_t CTRL_MCD  = 10'b0000_0000_01;
  localparam ctrl_t CTRL_ERR  = 10'b1111_0001_00;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// pipe_ctrl_hazard_detect
//   Combinational load-use detector. It flags when the load in EX writes a
//   register that the instruction in ID actually reads. A load to x0 never
//   produces a hazard.
//   Inputs : id_rs1/id_rs2 and their read enables, ex_rd, ex_is_load.
//   Output : load_use.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_re,
  input  logic             id_rs2_re,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  output logic             load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_rs1_re && (id_rs1 == ex_rd);
  assign rs2_hit  = id_rs2_re && (id_rs2 == ex_rd);
  assign load_use = ex_is_load && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. It handles memory
//   wait states, fixed-latency multi-cycle EX ops, taken branches and
//   load-use hazards. Only one of these causes acts in a given cycle. The
//   control outputs are Mealy: they depend on the state and the current inputs.
//   Inputs : clk, rst (sync, active-high), ID/EX hazard info, branch info,
//            and the mem_req/mem_ack handshake.
//   Outputs: stall_* (hold register), flush_* (load bubble), pc_redirect and
//            pc_target, mc_done, the sticky bus_err, and the saturating
//            stall_cycles counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LAT  = 32,
  parameter int MEM_TMO = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_re,
  input  logic             id_rs2_re,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_mc_start,
  input  logic             ex_br_taken,
  input  logic [31:0]      ex_br_target,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             flush_mem_wb,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             mc_done,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MC_W = $clog2(MC_LAT + 1);
  localparam int WT_W = $clog2(MEM_TMO + 1);

  state_e           state_q, state_d;
  logic [MC_W-1:0]  mc_cnt_q, mc_cnt_d;
  logic [WT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             load_use;
  ctrl_t            ctrl;

  pipe_ctrl_hazard_detect u_hazard (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rs1_re  (id_rs1_re),
    .id_rs2_re  (id_rs2_re),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .load_use   (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      mc_cnt_q       <= '0;
      wait_cnt_q     <= '0;
      bus_err_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mc_cnt_q       <= mc_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      bus_err_q      <= bus_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // A release cycle (ack seen, or the last MC cycle) drives no stall and no
  // action. Any branch or load-use that was held in the frozen stages is
  // still present and is picked up by the RUN priority on the next cycle.
  always_comb begin
    state_d        = state_q;
    mc_cnt_d       = mc_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    bus_err_d      = bus_err_q;
    ctrl           = CTRL_NONE;
    stall_cycles_d = stall_cycles_q;

    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ack) begin
          ctrl       = CTRL_MEM;
          wait_cnt_d = WT_W'(1);
          state_d    = ST_MEM_WAIT;
        end else if (ex_mc_start) begin
          ctrl     = CTRL_MC;
          mc_cnt_d = MC_W'(MC_LAT - 1);
          state_d  = ST_MC_BUSY;
        end else if (ex_br_taken) begin
          ctrl = CTRL_BR;
        end else if (load_use) begin
          ctrl = CTRL_LU;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          wait_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          ctrl = CTRL_MEM;
          // The counter stops at the timeout so that it cannot wrap.
          if (wait_cnt_q == WT_W'(MEM_TMO)) begin
            bus_err_d = 1'b1;
            state_d   = ST_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + WT_W'(1);
          end
        end
      end
      ST_MC_BUSY: begin
        if (mc_cnt_q == '0) begin
          ctrl    = CTRL_MCD;
          state_d = ST_RUN;
        end else begin
          ctrl     = CTRL_MC;
          mc_cnt_d = mc_cnt_q - MC_W'(1);
        end
      end
      ST_ERR: begin
        ctrl = CTRL_ERR;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // No pipeline action is allowed while the pipeline itself is in reset.
    if (rst) begin
      ctrl = CTRL_NONE;
    end

    if (ctrl.stall_pc && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  assign stall_pc     = ctrl.stall_pc;
  assign stall_if_id  = ctrl.stall_if_id;
  assign stall_id_ex  = ctrl.stall_id_ex;
  assign stall_ex_mem = ctrl.stall_ex_mem;
  assign flush_if_id  = ctrl.flush_if_id;
  assign flush_id_ex  = ctrl.flush_id_ex;
  assign flush_ex_mem = ctrl.flush_ex_mem;
  assign flush_mem_wb = ctrl.flush_mem_wb;
  assign pc_redirect  = ctrl.pc_redirect;
  assign mc_done      = ctrl.mc_done;
  assign pc_target    = ex_br_target;
  assign bus_err      = bus_err_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//   Self-checking bench for pipe_ctrl. It uses MC_LAT=4, MEM_TMO=8 and a
//   narrow 5-bit stall counter, so that saturation is reachable.
//   For each cycle, the expected control vector is pushed to a queue when
//   the stimulus is driven. It is popped and compared when the Mealy
//   outputs are sampled, half a cycle later.
module tb_pipe_ctrl;

  localparam int CNT_W = 5;

  // Bit order: stall pc,if_id,id_ex,ex_mem | flush if_id,id_ex,ex_mem,mem_wb | redirect, mc_done
  localparam logic [9:0] C_NONE = 10'b0000_0000_00;
  localparam logic [9:0] C_MEM  = 10'b1111_0001_00;
  localparam logic [9:0] C_MC   = 10'b1110_0010_00;
  localparam logic [9:0] C_BR   = 10'b0000_1100_10;
  localparam logic [9:0] C_LU   = 10'b1100_0100_00;
  localparam logic [9:0] C_MCD  = 10'b0000_0000_01;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic             id_rs1_re = 1'b0, id_rs2_re = 1'b0;
  logic             ex_is_load = 1'b0, ex_mc_start = 1'b0, ex_br_taken = 1'b0;
  logic [31:0]      ex_br_target = '0;
  logic             mem_req = 1'b0, mem_ack = 1'b0;
  logic             stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic             flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic             pc_redirect, mc_done, bus_err;
  logic [31:0]      pc_target;
  logic [CNT_W-1:0] stall_cycles;

  logic [9:0] ctrl;
  logic [9:0] exp_q[$];
  logic [9:0] exp_v;
  int         checks = 0;
  int         errors = 0;

  assign ctrl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                 flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
                 pc_redirect, mc_done};

  always #5 clk = ~clk;

  pipe_ctrl #(.MC_LAT(4), .MEM_TMO(8), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_re    (id_rs1_re),
    .id_rs2_re    (id_rs2_re),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .ex_mc_start  (ex_mc_start),
    .ex_br_taken  (ex_br_taken),
    .ex_br_target (ex_br_target),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .stall_pc     (stall_pc),
    .stall_if_id  (stall_if_id),
    .stall_id_ex  (stall_id_ex),
    .stall_ex_mem (stall_ex_mem),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .flush_ex_mem (flush_ex_mem),
    .flush_mem_wb (flush_mem_wb),
    .pc_redirect  (pc_redirect),
    .pc_target    (pc_target),
    .mc_done      (mc_done),
    .bus_err      (bus_err),
    .stall_cycles (stall_cycles)
  );

  // Drive the inputs. This task does not compare anything.
  task automatic set_in(input logic mreq, input logic mack, input logic mc,
                        input logic br, input logic ld, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic re1,
                        input logic [4:0] rs2, input logic re2);
    mem_req = mreq; mem_ack = mack; ex_mc_start = mc; ex_br_taken = br;
    ex_is_load = ld; ex_rd = rd; id_rs1 = rs1; id_rs1_re = re1;
    id_rs2 = rs2; id_rs2_re = re2;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    set_in(1, 0, 1, 1, 1, 5'd3, 5'd3, 1, 5'd0, 0);
    exp_q.push_back(C_NONE);
    #4;
    exp_v = exp_q.pop_front();
    checks++;
    if (ctrl !== exp_v) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl, exp_v);
    end
    checks++;
    if (bus_err !== 1'b0 || stall_cycles !== '0) begin
      errors++; $display("[TB] FAIL reset_regs: bus_err %b stall_cycles %0d expected 0/0", bus_err, stall_cycles);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      case (i)
        0: begin set_in(0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0); exp_q.push_back(C_LU); end
        1: begin set_in(0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1); exp_q.push_back(C_NONE); end
        2: begin set_in(0, 0, 0, 0, 1, 5'd7, 5'd1, 1, 5'd7, 1); exp_q.push_back(C_LU); end
        3: begin set_in(0, 0, 0, 0, 1, 5'd9, 5'd9, 0, 5'd9, 0); exp_q.push_back(C_NONE); end
        4: begin set_in(1, 1, 0, 0, 1, 5'd4, 5'd4, 1, 5'd0, 0); exp_q.push_back(C_LU); end
        default: begin set_in(0, 0, 0, 0, 0, 5'd5, 5'd5, 1, 5'd0, 0); exp_q.push_back(C_NONE); end
      endcase
      #4;
      exp_v = exp_q.pop_front();
      checks++;
      if (ctrl !== exp_v) begin
        errors++; $display("[TB] FAIL load_use cyc%0d: got %b expected %b", i, ctrl, exp_v);
      end
    end
    checks++;
    if (stall_cycles !== CNT_W'(3)) begin
      errors++; $display("[TB] FAIL load_use_count: got %0d expected 3", stall_cycles);
    end
  endtask

  task automatic test_branch();
    do_reset();
    ex_br_target = 32'h80;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      case (i)
        0: begin set_in(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_BR); end
        1: begin set_in(0, 0, 0, 1, 1, 5'd6, 5'd6, 1, 5'd0, 0); exp_q.push_back(C_BR); end
        default: begin set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_NONE); end
      endcase
      #4;
      exp_v = exp_q.pop_front();
      checks++;
      if (ctrl !== exp_v) begin
        errors++; $display("[TB] FAIL branch cyc%0d: got %b expected %b", i, ctrl, exp_v);
      end
    end
    checks++;
    if (pc_target !== 32'h80) begin
      errors++; $display("[TB] FAIL branch_target: got %h expected 00000080", pc_target);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      case (i)
        0, 1, 2: begin set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_MEM); end
        3: begin set_in(1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_NONE); end
        default: begin set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_NONE); end
      endcase
      #4;
      exp_v = exp_q.pop_front();
      checks++;
      if (ctrl !== exp_v) begin
        errors++; $display("[TB] FAIL mem_wait cyc%0d: got %b expected %b", i, ctrl, exp_v);
      end
    end
    checks++;
    if (stall_cycles !== CNT_W'(3) || bus_err !== 1'b0) begin
      errors++; $display("[TB] FAIL mem_wait_count: got %0d/%b expected 3/0", stall_cycles, bus_err);
    end
  endtask

  task automatic test_multicycle();
    do_reset();
    ex_br_target = 32'h44;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      case (i)
        0: begin set_in(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_MC); end
        1, 3: begin set_in(0, 0, 1, 1, 1, 5'd2, 5'd2, 1, 5'd0, 0); exp_q.push_back(C_MC); end
        2: begin set_in(1, 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_MC); end
        4: begin set_in(0, 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_MCD); end
        5: begin set_in(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_BR); end
        default: begin set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_NONE); end
      endcase
      #4;
      exp_v = exp_q.pop_front();
      checks++;
      if (ctrl !== exp_v) begin
        errors++; $display("[TB] FAIL multicycle cyc%0d: got %b expected %b", i, ctrl, exp_v);
      end
    end
    checks++;
    if (stall_cycles !== CNT_W'(4)) begin
      errors++; $display("[TB] FAIL multicycle_count: got %0d expected 4", stall_cycles);
    end
  endtask

  task automatic test_timeout();
    logic             exp_err;
    logic [CNT_W-1:0] exp_cnt;
    do_reset();
    for (int i = 0; i < 41; i++) begin
      @(posedge clk); #1;
      set_in(1, (i >= 20), 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
      exp_q.push_back(C_MEM);
      exp_err = (i >= 9);
      exp_cnt = (i >= 31) ? CNT_W'(31) : CNT_W'(i);
      #4;
      exp_v = exp_q.pop_front();
      checks++;
      if (ctrl !== exp_v || bus_err !== exp_err || stall_cycles !== exp_cnt) begin
        errors++;
        $display("[TB] FAIL timeout cyc%0d: ctrl %b err %b cnt %0d expected %b %b %0d",
                 i, ctrl, bus_err, stall_cycles, exp_v, exp_err, exp_cnt);
      end
    end
    do_reset();
    @(posedge clk); #1;
    set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    exp_q.push_back(C_NONE);
    #4;
    exp_v = exp_q.pop_front();
    checks++;
    if (ctrl !== exp_v || bus_err !== 1'b0 || stall_cycles !== '0) begin
      errors++; $display("[TB] FAIL timeout_reset: ctrl %b err %b cnt %0d expected %b 0 0", ctrl, bus_err, stall_cycles, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ex_br_target = 32'hC0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      case (i)
        0, 1: begin set_in(1, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_MEM); end
        2: begin set_in(1, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_NONE); end
        3: begin set_in(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_BR); end
        default: begin set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_NONE); end
      endcase
      #4;
      exp_v = exp_q.pop_front();
      checks++;
      if (ctrl !== exp_v) begin
        errors++; $display("[TB] FAIL br_mem cyc%0d: got %b expected %b", i, ctrl, exp_v);
      end
    end
    // Reset in the middle of MC_BUSY, then run a fresh multi-cycle op.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      rst = (i == 2);
      case (i)
        0, 1: begin set_in(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_MC); end
        2: begin set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_NONE); end
        3: begin set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_NONE); end
        4, 5, 6, 7: begin set_in(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_MC); end
        8: begin set_in(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_MCD); end
        default: begin set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0); exp_q.push_back(C_NONE); end
      endcase
      #4;
      exp_v = exp_q.pop_front();
      checks++;
      if (ctrl !== exp_v) begin
        errors++; $display("[TB] FAIL rst_mc cyc%0d: got %b expected %b", i, ctrl, exp_v);
      end
      if (i == 3) begin
        checks++;
        if (stall_cycles !== '0 || bus_err !== 1'b0) begin
          errors++; $display("[TB] FAIL rst_mc_regs: cnt %0d err %b expected 0 0", stall_cycles, bus_err);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_multicycle();
    test_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
